// File: rtl/modexp_pkg.sv
// Shared types and width derivations for the modular exponentiation unit.
package modexp_pkg;

    // Sequencer states; NEXT is the scan-advance step between bit positions.
    typedef enum logic [2:0] {
        IDLE,
        PRE_X,
        PRE_A,
        MUL,
        SQR,
        NEXT,
        POST,
        FIN
    } state_e;

    // Internal Montgomery width: two guard bits keep the partial sum below 2^IW.
    function automatic int iw_of(input int width);
        return width + 2;
    endfunction

    // Cycles per Montgomery product: IW add/shift steps plus one reduce step.
    function automatic int l_of(input int width);
        return width + 3;
    endfunction

    localparam int DEF_WIDTH = 8;
    localparam int DEF_IW    = iw_of(DEF_WIDTH);
    localparam int DEF_L     = l_of(DEF_WIDTH);

endpackage

// File: rtl/mmm_serial.sv
// Bit-serial Montgomery multiplier: R = A*B*2^-IW mod M, fully reduced.
// A go cycle loads the operands and performs the first add/shift step;
// IW-1 further steps follow, then rdy flags the final cycle in which R is
// the conditionally-subtracted accumulator. go restarts it at any time.
module mmm_serial
    import modexp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             go,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] R,
    output logic             rdy
);

    localparam int IW = iw_of(WIDTH);
    localparam int CW = $clog2(IW + 1);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] acc_q, acc_d;
    logic [IW-1:0] a_q, a_d;
    logic [IW-1:0] b_q, b_d;
    logic [IW-1:0] m_q, m_d;
    logic [IW-1:0] red;

    // One step: add the selected multiplicand, make it even with M, halve.
    function automatic logic [IW-1:0] mstep(input logic [IW-1:0] acc, input logic abit,
                                            input logic [IW-1:0] b, input logic [IW-1:0] m);
        logic [IW:0] t;
        t = {1'b0, acc} + (abit ? {1'b0, b} : '0);
        if (t[0]) t = t + {1'b0, m};
        return t[IW:1];
    endfunction

    // Load on go, otherwise iterate until the reduce cycle, then go idle.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        m_d   = m_q;
        if (go) begin
            b_d   = {{(IW-WIDTH){1'b0}}, B};
            m_d   = {{(IW-WIDTH){1'b0}}, M};
            acc_d = mstep('0, A[0], b_d, m_d);
            a_d   = {{(IW-WIDTH){1'b0}}, A} >> 1;
            cnt_d = CW'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q != CW'(IW)) begin
                acc_d = mstep(acc_q, a_q[0], b_q, m_q);
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
            end else begin
                run_d = 1'b0;
            end
        end
    end

    // Accumulator is below 2M after IW steps, so one subtract reduces it.
    always_comb begin
        red = (acc_q >= m_q) ? (acc_q - m_q) : acc_q;
    end

    assign R   = WIDTH'(red);
    assign rdy = run_q && !go && (cnt_q == CW'(IW));

    // Datapath registers, frozen while ena is low.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
        end else if (ena) begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            m_q   <= m_d;
        end
    end

endmodule

// File: rtl/modexp_unit.sv
// Modular exponentiation C = P^E mod M using right-to-left binary scanning
// over a single shared Montgomery multiplier. Operations are chained with
// no gap cycles: the completing product's last cycle also selects the next
// operation, so latency is exactly K*L+1 cycles.
module modexp_unit
    import modexp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Const,
    output logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int IDXW = $clog2(EXP_WIDTH) + 1;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     p_q, p_d, m_q, m_d, k_q, k_d;
    logic [WIDTH-1:0]     x_q, x_d, a_q, a_d, c_q, c_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 first_q, first_d;
    logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [WIDTH-1:0]     mul_a, mul_b, mul_r;
    logic                 mul_rdy;

    // Work for bit j: multiply if set, else square if a higher bit is set, else finish.
    function automatic state_e bit_state(input logic [EXP_WIDTH-1:0] e, input logic [IDXW-1:0] j);
        logic [EXP_WIDTH-1:0] s;
        s = e >> j;
        if (s[0])             return MUL;
        else if ((s >> 1) != '0) return SQR;
        else                  return POST;
    endfunction

    // Operand routing into the shared multiplier for the active operation.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            PRE_X:   begin mul_a = p_q;         mul_b = k_q;         end
            PRE_A:   begin mul_a = WIDTH'(1);   mul_b = k_q;         end
            MUL:     begin mul_a = a_q;         mul_b = x_q;         end
            SQR:     begin mul_a = x_q;         mul_b = x_q;         end
            POST:    begin mul_a = a_q;         mul_b = WIDTH'(1);   end
            default: begin mul_a = '0;          mul_b = '0;          end
        endcase
    end

    mmm_serial #(.WIDTH(WIDTH)) u_mmm (
        .clk  (clk),
        .rstb (rstb),
        .ena  (ena),
        .go   (first_q),
        .A    (mul_a),
        .B    (mul_b),
        .M    (m_q),
        .R    (mul_r),
        .rdy  (mul_rdy)
    );

    // Sequencer: next state, operand latching, scan index and result flags.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        k_d     = k_q;
        x_d     = x_q;
        a_d     = a_q;
        c_d     = c_q;
        idx_d   = idx_q;
        first_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (clear) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b0;
            c_d     = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    p_d    = P;
                    e_d    = E;
                    m_d    = M;
                    k_d    = Const;
                    x_d    = '0;
                    a_d    = '0;
                    c_d    = '0;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    // Even modulus has no Montgomery inverse: skip straight to the error exit.
                    if (!M[0])          state_d = FIN;
                    else if (E == '0)   state_d = PRE_A;
                    else                state_d = PRE_X;
                    first_d = M[0];
                end
                PRE_X: if (mul_rdy) begin
                    x_d     = mul_r;
                    state_d = PRE_A;
                    first_d = 1'b1;
                end
                PRE_A: if (mul_rdy) begin
                    a_d     = mul_r;
                    state_d = (e_q == '0) ? POST : bit_state(e_q, '0);
                    first_d = 1'b1;
                end
                MUL: if (mul_rdy) begin
                    a_d     = mul_r;
                    state_d = (((e_q >> idx_q) >> 1) != '0) ? SQR : POST;
                    first_d = 1'b1;
                end
                // Squaring ends a bit position; the index advance is folded in here.
                SQR: if (mul_rdy) begin
                    x_d     = mul_r;
                    idx_d   = idx_q + IDXW'(1);
                    state_d = bit_state(e_q, idx_q + IDXW'(1));
                    first_d = 1'b1;
                end
                NEXT: begin
                    state_d = bit_state(e_q, idx_q);
                    first_d = 1'b1;
                end
                POST: if (mul_rdy) begin
                    c_d     = mul_r;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end
                FIN: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!m_q[0]) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and operand registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            p_q     <= '0;
            e_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            a_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            p_q     <= p_d;
            e_q     <= e_d;
            m_q     <= m_d;
            k_q     <= k_d;
            x_q     <= x_d;
            a_q     <= a_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign C    = c_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_modexp_unit.sv
// Directed bench for modexp_unit at WIDTH=8, M=221, Const=2^20 mod 221=152.
module tb_modexp_unit;

    logic       clk = 1'b0;
    logic       rstb, ena, clear, start;
    logic [7:0] P, E, M, Const;
    logic [7:0] C;
    logic       busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    modexp_unit #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .clear (clear),
        .start (start),
        .P     (P),
        .E     (E),
        .M     (M),
        .Const (Const),
        .C     (C),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    // Present operands and a one-cycle start; afterwards we sit #1 into cycle 1.
    task automatic start_op(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
        @(negedge clk);
        P = p; E = e; M = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Wait (bounded) for done; ena is pulled low for cycles [lo_from, lo_from+lo_n).
    task automatic wait_done(input int lo_from, input int lo_n, output int at);
        at = -1;
        while (cyc < 400) begin
            @(negedge clk);
            ena = !(cyc >= lo_from && cyc < lo_from + lo_n);
            if (done) begin
                at = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        ena = 1'b1;
    endtask

    task automatic run(input string tag, input logic [7:0] p, input logic [7:0] e, input logic [7:0] m,
                       input int exp_at, input logic [7:0] exp_c, input logic exp_err);
        int at;
        start_op(p, e, m);
        chk({tag, "_busy1"}, busy, 1);
        wait_done(1000, 0, at);
        chk({tag, "_lat"}, at, exp_at);
        chk({tag, "_c"}, C, exp_c);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, C, exp_c);
    endtask

    initial begin
        int at;
        int dcount;
        rstb = 1'b0; ena = 1'b1; clear = 1'b0; start = 1'b0;
        P = 8'd0; E = 8'd0; M = 8'd221; Const = 8'd152;
        #12;
        chk("rst_c", C, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rstb = 1'b1;

        // 7^5 mod 221 = 11; K=7, L=11 -> 78
        run("base", 8'd7, 8'd5, 8'd221, 78, 8'd11, 1'b0);
        // E=0 -> K=2 -> 23, result 1
        run("e0", 8'd7, 8'd0, 8'd221, 23, 8'd1, 1'b0);
        // even modulus -> done at cycle 2 with err
        run("even", 8'd7, 8'd5, 8'd220, 2, 8'd0, 1'b1);
        // 2^8 = 256 mod 221 = 35; K=3+1+3=7
        run("p2e8", 8'd2, 8'd8, 8'd221, 78, 8'd35, 1'b0);
        // 200 = -21; (-21)^3 = 21 mod 221; K=3+2+1=6 -> 67
        run("p200e3", 8'd200, 8'd3, 8'd221, 67, 8'd21, 1'b0);
        // E=1: K=4 -> 45
        run("p220e1", 8'd220, 8'd1, 8'd221, 45, 8'd220, 1'b0);
        run("p0e1", 8'd0, 8'd1, 8'd221, 45, 8'd0, 1'b0);

        // ena low for 10 cycles mid-run stretches latency by 10
        start_op(8'd7, 8'd5, 8'd221);
        wait_done(20, 10, at);
        chk("ena_lat", at, 88);
        chk("ena_c", C, 11);

        // clear at cycle 30 aborts with no done pulse
        start_op(8'd7, 8'd5, 8'd221);
        step_to(30);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_c", C, 0);
        dcount = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("clr_nodone", dcount, 0);
        run("after_clr", 8'd7, 8'd5, 8'd221, 78, 8'd11, 1'b0);

        // second start while busy is ignored, operand changes have no effect
        start_op(8'd7, 8'd5, 8'd221);
        step_to(5);
        P = 8'd3; E = 8'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        wait_done(1000, 0, at);
        chk("restart_lat", at, 78);
        chk("restart_c", C, 11);

        // start and clear together: clear wins
        @(negedge clk);
        P = 8'd7; E = 8'd5; start = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("sc_busy", busy, 0);
        chk("sc_c", C, 0);

        // reset mid-operation discards everything
        start_op(8'd7, 8'd5, 8'd221);
        step_to(40);
        rstb = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_c", C, 0);
        @(negedge clk);
        rstb = 1'b1;
        run("after_rst", 8'd7, 8'd5, 8'd221, 78, 8'd11, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/modexp_unit.md
MODEXP_UNIT -- requirements
Module: modexp_unit

Interface
REQ-001 Parameter WIDTH, default 8: bit width of P, M, Const and C; internal datapath width is IW = WIDTH+2.
REQ-002 Parameter EXP_WIDTH, default 8: bit width of E, independent of WIDTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstb  input  1  asynchronous, active-low reset.
REQ-005 ena  input  1  clock enable; when low, every register holds.
REQ-006 clear  input  1  synchronous abort, active high, qualified by ena.
REQ-007 start  input  1  single-cycle request; sampled only in IDLE with ena high.
REQ-008 P  input  WIDTH  base, required < M.
REQ-009 E  input  EXP_WIDTH  exponent.
REQ-010 M  input  WIDTH  modulus, required odd and >= 3.
REQ-011 Const  input  WIDTH  Montgomery constant, 2^(2*IW) mod M.
REQ-012 C  output  WIDTH  result P^E mod M; held until the next accepted start or clear.
REQ-013 busy  output  1  high from the cycle after start is accepted until done.
REQ-014 done  output  1  one-cycle pulse when C is valid.
REQ-015 err  output  1  set with done when M is even; cleared by the next accepted start.

Function
REQ-016 On accepted start, P, E, M and Const SHALL be latched; input changes while busy SHALL have no effect.
REQ-017 A single shared bit-serial Montgomery multiplier SHALL compute mont(a,b) = a*b*2^-IW mod M, fully reduced to < M.
REQ-018 Each mont operation SHALL take exactly L = WIDTH+3 enabled cycles: IW add/shift iterations plus one conditional-subtract cycle.
REQ-019 The FSM states SHALL be IDLE, PRE_X, PRE_A, MUL, SQR, NEXT, POST, FIN.
REQ-020 PRE_X: X = mont(P,Const). PRE_A: A = mont(1,Const).
REQ-021 Right-to-left scan, bit i from 0 upward: MUL (A = mont(A,X)) only when E[i]=1; SQR (X = mont(X,X)) only when a higher set bit of E remains; NEXT advances i.
REQ-022 POST: A = mont(A,1); FIN: C <= A, done=1, busy=0, return to IDLE.
REQ-023 Operation count K = 3 + popcount(E) + msb_index(E) for E != 0; latency from the start cycle to done SHALL be K*L+1 cycles.
REQ-024 E = 0: PRE_X and scan skipped; K = 2; C = 1.
REQ-025 Even M: no multiplication; done and err SHALL assert 2 cycles after start; C = 0.
REQ-026 A start asserted while busy SHALL be ignored; start and clear in the same cycle: clear wins.
REQ-027 clear in any state SHALL return to IDLE next enabled cycle, with busy=0, done=0, err=0, C=0.
REQ-028 ena low mid-operation SHALL stretch latency by exactly the number of disabled cycles, with results unchanged.

Reset
REQ-029 rstb low SHALL asynchronously force IDLE, C=0, busy=0, done=0, err=0, and all latched operands and accumulators to 0.
REQ-030 Reset mid-operation SHALL discard the computation; the first accepted start after release SHALL behave as from power-up.

Structure
REQ-031 Shared package modexp_pkg SHALL hold the FSM state enum and the IW/L width-derivation constants.
REQ-032 The Montgomery multiplier SHALL be one sub-module, mmm_serial (ports ena, rstb, clk, go, A, B, M, R, rdy); the top holds the FSM, operand latches and scan index.

Verification (WIDTH=8, EXP_WIDTH=8, M=221, Const=152)
REQ-033 P=7, E=5, start -> done at cycle 78 (K=7, L=11), C=11, err=0.
REQ-034 P=7, E=0 -> done at cycle 23, C=1.
REQ-035 M=220, P=7, E=5 -> done at cycle 2, err=1, C=0.
REQ-036 P=7, E=5, ena low for 10 cycles mid-run -> done at cycle 88, C=11.
REQ-037 P=7, E=5, clear at cycle 30 -> IDLE, busy=0, no done pulse; re-run gives C=11.
REQ-038 Second start at cycle 5 with P=3 -> ignored; C=11 at cycle 78.
